// File: rtl/imem_loader.sv
// Instruction memory loader: turns a length-prefixed byte stream into
// little-endian 32-bit word writes starting at BASE_ADDR.
module imem_loader #(
    parameter int DEPTH     = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  word_count
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0]  DEPTH_B = 8'(DEPTH);
    localparam logic [31:0] BASE_W  = 32'(BASE_ADDR);

    state_t      state;
    state_t      state_n;
    logic [1:0]  lane;
    logic [7:0]  len;
    logic        xfer;
    logic        hdr_bad;
    logic        last;

    assign byte_ready = (state == HDR) || (state == DATA);
    assign wr_en      = (state == WRITE);
    assign busy       = (state == HDR) || (state == DATA) || (state == WRITE);
    assign xfer       = byte_valid && byte_ready;
    assign hdr_bad    = (byte_data == 8'd0) || (byte_data > DEPTH_B);
    assign last       = (({2'b00, word_count} + 8'd1) == len);

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_n = HDR;
            end
            HDR: begin
                if (xfer) state_n = hdr_bad ? ERR : DATA;
            end
            DATA: begin
                if (xfer && lane == 2'd3) state_n = WRITE;
            end
            WRITE: begin
                state_n = last ? DONE : DATA;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lane       <= 2'd0;
            len        <= 8'd0;
            wr_addr    <= BASE_W;
            wr_data    <= 32'd0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= 6'd0;
        end else begin
            state <= state_n;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_count <= 6'd0;
                        lane       <= 2'd0;
                        wr_addr    <= BASE_W;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        if (hdr_bad) error <= 1'b1;
                        else         len   <= byte_data;
                    end
                end
                DATA: begin
                    // lane 0 lands in the least significant byte
                    if (xfer) begin
                        wr_data[{lane, 3'b000} +: 8] <= byte_data;
                        lane <= lane + 2'd1;
                    end
                end
                WRITE: begin
                    word_count <= word_count + 6'd1;
                    wr_addr    <= wr_addr + 32'd4;
                    lane       <= 2'd0;
                    if (last) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [5:0]  word_count;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb[$];
    logic [31:0] img[0:63];
    logic [31:0] last_addr = 32'hffff_ffff;

    imem_loader #(.DEPTH(32), .BASE_ADDR(0)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .error(error),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            logic [63:0] e;
            chk("ready_in_write", 32'(byte_ready), 32'd0);
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL spurious_wr got addr %h expected no write", wr_addr);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", wr_addr, e[63:32]);
                chk("wr_data", wr_data, e[31:0]);
                last_addr = wr_addr;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        vectors++;
        assert (t < 50) else begin
            miscompares++;
            $error("FAIL ready_timeout got %0d cycles expected <50", t);
        end
        @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < 100) begin
            @(negedge clock);
            t++;
        end
        vectors++;
        assert (t < 100) else begin
            miscompares++;
            $error("FAIL end_timeout got %0d cycles expected <100", t);
        end
    endtask

    task automatic load(input int n, input bit gap, input int ign_word);
        pulse_start();
        push_byte(8'(n));
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clock);
        end
        for (int w = 0; w < n; w++) begin
            sb.push_back({32'(4 * w), img[w]});
            for (int k = 0; k < 4; k++) begin
                push_byte(img[w][8*k +: 8]);
                if (w == ign_word && k == 1) begin
                    byte_valid = 1'b0;
                    pulse_start();
                    chk("ign_busy", 32'(busy), 32'd1);
                    chk("ign_count", 32'(word_count), 32'(w));
                    chk("ign_addr", wr_addr, 32'(4 * w));
                end
                if (gap) begin
                    byte_valid = 1'b0;
                    @(negedge clock);
                end
            end
        end
        byte_valid = 1'b0;
        wait_end();
        chk("ld_done", 32'(done), 32'd1);
        chk("ld_busy", 32'(busy), 32'd0);
        chk("ld_error", 32'(error), 32'd0);
        chk("ld_count", 32'(word_count), 32'(n));
        chk("ld_addr", wr_addr, 32'(4 * n));
        chk("ld_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic bad_hdr(input logic [7:0] n);
        pulse_start();
        push_byte(n);
        byte_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("bad_error", 32'(error), 32'd1);
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_ready", 32'(byte_ready), 32'd0);
        chk("bad_done", 32'(done), 32'd0);
        chk("bad_count", 32'(word_count), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_addr"}, wr_addr, 32'd0);
        chk({tag, "_data"}, wr_data, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (2) @(negedge clock);
        chk_reset_state("rst");
        reset = 1'b0;
        @(negedge clock);

        // idle bytes are refused
        byte_valid = 1'b1;
        byte_data = 8'h55;
        @(negedge clock);
        chk("idle_ready", 32'(byte_ready), 32'd0);
        byte_valid = 1'b0;

        img[0] = 32'h0800_0213;
        img[1] = 32'h0000_00b3;
        load(2, 1'b0, -1);
        load(2, 1'b1, -1);

        bad_hdr(8'h00);
        bad_hdr(8'h21);
        load(2, 1'b0, -1);

        for (int i = 0; i < 32; i++) img[i] = $urandom;
        load(32, 1'b0, -1);
        chk("max_last_addr", last_addr, 32'h7c);

        // reset after two data bytes of the first word
        pulse_start();
        push_byte(8'h02);
        push_byte(8'haa);
        push_byte(8'hbb);
        byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk_reset_state("mid");
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        img[0] = 32'h1234_5678;
        img[1] = 32'h9abc_def0;
        load(2, 1'b0, -1);

        for (int i = 0; i < 3; i++) img[i] = $urandom;
        load(3, 1'b0, 1);

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
